// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and the
// multiplier error harness that consumes its flags.
package div_pkg;

    // Controller states of the iterative divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default operand width (16x16 multiplier inverse).
    localparam int DIV_W = 16;

    // Saturated quotient returned on divide-by-zero or overflow.
    localparam logic [DIV_W-1:0] ALL_ONES = {DIV_W{1'b1}};

    // Error flags carried alongside each result.
    typedef struct packed {
        logic dbz;
        logic ovf;
    } div_flags_t;

    localparam div_flags_t FLAG_NONE = '{dbz: 1'b0, ovf: 1'b0};
    localparam div_flags_t FLAG_OVF  = '{dbz: 1'b0, ovf: 1'b1};
    localparam div_flags_t FLAG_DBZ  = '{dbz: 1'b1, ovf: 1'b0};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   r_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_out,
    output logic         q_bit
);

    logic [W:0] t;
    logic [W:0] diff;
    logic       fits;

    // The bit shifted out of r_in[W] is weighted 2^(W+1); if it were ever set
    // the trial value is certainly >= divisor, so it forces a subtraction.
    always_comb begin
        t     = {r_in[W-1:0], bit_in};
        diff  = t - {1'b0, divisor};
        fits  = r_in[W] | (t >= {1'b0, divisor});
        q_bit = fits;
        r_out = fits ? diff : t;
    end

endmodule

// File: rtl/seq_div32x16.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, valid/ready handshakes on both sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and the result stays stable until the cycle out_ready is sampled high.
// Outputs are registered and hold their last values outside DONE.
module seq_div32x16
    import div_pkg::*;
#(
    parameter  int W     = 16,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

    localparam logic [W-1:0]     QUO_SAT  = {W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       rem_q, rem_d;     // partial remainder R
    logic [W-1:0]     sh_q, sh_d;       // dividend low bits out, quotient bits in
    logic [W-1:0]     dvs_q, dvs_d;     // captured divisor
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rmd_q, rmd_d;
    div_flags_t       flags_q, flags_d;

    logic [W:0]       step_r;
    logic             step_q;
    logic [W-1:0]     div_hi;
    logic [W-1:0]     div_lo;

    assign div_hi = dividend[2*W-1:W];
    assign div_lo = dividend[W-1:0];

    div_step #(.W(W)) u_step (
        .r_in    (rem_q),
        .bit_in  (sh_q[W-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    // State, datapath and result registers; reset abandons any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            flags_q <= FLAG_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and datapath: operand capture, one iteration per BUSY cycle,
    // early completion for divide-by-zero and quotient overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        quo_d   = QUO_SAT;
                        rmd_d   = div_lo;
                        flags_d = FLAG_DBZ;
                        state_d = DONE;
                    end else if (div_hi >= divisor) begin
                        quo_d   = QUO_SAT;
                        rmd_d   = div_lo;
                        flags_d = FLAG_OVF;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, div_hi};
                        sh_d    = div_lo;
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_r;
                sh_d  = {sh_q[W-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    quo_d   = {sh_q[W-2:0], step_q};
                    rmd_d   = step_r[W-1:0];
                    flags_d = FLAG_NONE;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign dbz       = flags_q.dbz;
    assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_seq_div32x16.sv
// Directed bench for seq_div32x16: reset values, normal division,
// divide-by-zero / overflow, backpressure, mid-operation reset, and a short
// randomised sweep against integer division.
module tb_seq_div32x16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dbz;
  logic        ovf;

  int checks;
  int failures;

  localparam int MAX_WAIT = 64;

  seq_div32x16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one operand pair, count cycles until out_valid, capture
  // the result, then complete the output handshake. lat = 1 means out_valid
  // in the cycle right after the accept edge.
  task automatic run_op(input logic [31:0] dd, input logic [15:0] dv,
                        output int lat, output logic [15:0] q, output logic [15:0] r,
                        output logic z, output logic o, output logic rdy_after);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = dbz;
    o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rdy_after = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 16'h0) begin failures++; $display("FAIL reset_quotient got=%h exp=0000", quotient); end
    checks++; if (remainder !== 16'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0000", remainder); end
    checks++; if ({dbz, ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {dbz, ovf}); end
    rst = 1'b0;
    @(posedge clk); #1;
    // out_ready while idle must be ignored
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_ready got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_normal();
    logic [31:0] v_dd [5] = '{32'h000F4240, 32'h00123456, 32'h0000FFFF, 32'h0000ABCD, 32'hFFFEFFFF};
    logic [15:0] v_dv [5] = '{16'h03E8,     16'h0100,     16'h0007,     16'h0001,     16'hFFFF};
    logic [15:0] v_q  [5] = '{16'h03E8,     16'h1234,     16'h2492,     16'hABCD,     16'hFFFF};
    logic [15:0] v_r  [5] = '{16'h0000,     16'h0056,     16'h0001,     16'h0000,     16'hFFFE};
    int lat; logic [15:0] q, r; logic z, o, rdy;
    for (int i = 0; i < 5; i++) begin
      run_op(v_dd[i], v_dv[i], lat, q, r, z, o, rdy);
      checks++; if (lat !== 17) begin failures++; $display("FAIL norm%0d_latency got=%0d exp=17", i, lat); end
      checks++; if (q !== v_q[i]) begin failures++; $display("FAIL norm%0d_quotient got=%h exp=%h", i, q, v_q[i]); end
      checks++; if (r !== v_r[i]) begin failures++; $display("FAIL norm%0d_remainder got=%h exp=%h", i, r, v_r[i]); end
      checks++; if ({z, o} !== 2'b00) begin failures++; $display("FAIL norm%0d_flags got=%b exp=00", i, {z, o}); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL norm%0d_release got=%b exp=1", i, rdy); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] v_dd [5] = '{32'hDEADBEEF, 32'h12345678, 32'h00010000, 32'hFFFF0000, 32'h00000000};
    logic [15:0] v_dv [5] = '{16'h0000,     16'h1234,     16'h0001,     16'hFFFF,     16'h0000};
    logic [15:0] v_r  [5] = '{16'hBEEF,     16'h5678,     16'h0000,     16'h0000,     16'h0000};
    logic [1:0]  v_f  [5] = '{2'b10,        2'b01,        2'b01,        2'b01,        2'b10};
    int lat; logic [15:0] q, r; logic z, o, rdy;
    for (int i = 0; i < 5; i++) begin
      run_op(v_dd[i], v_dv[i], lat, q, r, z, o, rdy);
      checks++; if (lat !== 1) begin failures++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (q !== 16'hFFFF) begin failures++; $display("FAIL err%0d_quotient got=%h exp=ffff", i, q); end
      checks++; if (r !== v_r[i]) begin failures++; $display("FAIL err%0d_remainder got=%h exp=%h", i, r, v_r[i]); end
      checks++; if ({z, o} !== v_f[i]) begin failures++; $display("FAIL err%0d_flags got=%b exp=%b", i, {z, o}, v_f[i]); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL err%0d_release got=%b exp=1", i, rdy); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    int lat;
    dividend = 32'h00123456;
    divisor  = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // new operands held on the input while busy must not be captured
    dividend = 32'h000F4240;
    divisor  = 16'h03E8;
    wait_cnt = 1;
    while (!out_valid && wait_cnt < MAX_WAIT) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checks++; if (wait_cnt !== 17) begin failures++; $display("FAIL bp_latency got=%0d exp=17", wait_cnt); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'h1234 ||
          remainder !== 16'h0056 || dbz !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b q=%h r=%h z=%b o=%b exp v=1 rdy=0 q=1234 r=0056 z=0 o=0",
                 c, out_valid, in_ready, quotient, remainder, dbz, ovf);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    // in_valid still high: accepted on this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 17) begin failures++; $display("FAIL bp_second_latency got=%0d exp=17", lat); end
    checks++; if (quotient !== 16'h03E8 || remainder !== 16'h0000) begin failures++; $display("FAIL bp_second_result got=%h/%h exp=03e8/0000", quotient, remainder); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] q, r; logic z, o, rdy;
    dividend = 32'h00123456;
    divisor  = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_busy got rdy=%b v=%b exp rdy=0 v=0", in_ready, out_valid); end
    // quotient still shows the previous result (03e8) before reset
    #2;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_hs got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    checks++; if (quotient !== 16'h0 || remainder !== 16'h0) begin failures++; $display("FAIL midrst_data got=%h/%h exp=0000/0000", quotient, remainder); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'h00000064, 16'h000A, lat, q, r, z, o, rdy);
    checks++; if (lat !== 17) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=17", lat); end
    checks++; if (q !== 16'h000A || r !== 16'h0000) begin failures++; $display("FAIL midrst_next_result got=%h/%h exp=000a/0000", q, r); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] q, r; logic z, o, rdy;
    logic [31:0] dd; logic [15:0] dv, hi;
    logic [31:0] eq, er;
    logic [15:0] exp_q, exp_r; logic [1:0] exp_f;
    int kind;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        dv = 16'h0;
        hi = 16'($urandom_range(0, 65535));
      end else if (kind == 1) begin
        dv = 16'($urandom_range(1, 65535));
        hi = 16'($urandom_range(int'(dv), 65535));
      end else begin
        dv = (kind == 2) ? 16'h0001 : (kind == 3) ? 16'hFFFF : 16'($urandom_range(1, 65535));
        hi = 16'($urandom_range(0, int'(dv) - 1));
      end
      dd = {hi, 16'($urandom_range(0, 65535))};
      if (dv == 16'h0) begin
        exp_q = 16'hFFFF; exp_r = dd[15:0]; exp_f = 2'b10;
      end else if (hi >= dv) begin
        exp_q = 16'hFFFF; exp_r = dd[15:0]; exp_f = 2'b01;
      end else begin
        eq = dd / {16'h0, dv};
        er = dd % {16'h0, dv};
        exp_q = eq[15:0]; exp_r = er[15:0]; exp_f = 2'b00;
      end
      run_op(dd, dv, lat, q, r, z, o, rdy);
      checks++;
      if (q !== exp_q || r !== exp_r || {z, o} !== exp_f || lat !== ((exp_f == 2'b00) ? 17 : 1)) begin
        failures++;
        $display("FAIL rand%0d dd=%h dv=%h got q=%h r=%h f=%b lat=%0d exp q=%h r=%h f=%b",
                 n, dd, dv, q, r, {z, o}, lat, exp_q, exp_r, exp_f);
      end
      if (exp_f == 2'b00) begin
        checks++;
        if ({16'h0, q} * {16'h0, dv} + {16'h0, r} !== dd || r >= dv) begin
          failures++;
          $display("FAIL rand%0d_invariant dd=%h dv=%h got q=%h r=%h", n, dd, dv, q, r);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_normal();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_div32x16.md
Name: seq_div32x16

Overview:
- Iterative restoring divider. Computes a 2W-bit dividend divided by a W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- It is the inverse operation of the team's 16x16 recursive multipliers (a[15:0]·b[15:0] → 32-bit product).
- Used in the error-analysis harness to recover operands from approximate products (product / a vs. b).
- Takes one quotient bit per clock, with valid/ready handshakes on input and output.

Parameters:
- W, 16, divisor/quotient/remainder width; dividend is 2W bits.
- CNT_W, $clog2(W+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept operands.
- dividend  input  2W  numerator, unsigned.
- divisor  input  W  denominator, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- dbz  output  1  divide-by-zero flag.
- ovf  output  1  quotient-overflow flag (dividend[2W-1:W] >= divisor, divisor != 0).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset: state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; quotient=0; remainder=0; dbz=0; ovf=0; counter=0. Applies mid-operation, abandoning any result.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Accept on in_valid && in_ready; operands captured into internal registers. Input ports are not sampled again until the next IDLE.
- IDLE → DONE on accept when divisor==0:
  - dbz=1, ovf=0, quotient=all-ones, remainder=dividend[W-1:0].
  - out_valid in the cycle after accept.
- IDLE → DONE on accept when divisor!=0 and dividend[2W-1:W] >= divisor:
  - ovf=1, dbz=0, quotient=all-ones, remainder=dividend[W-1:0].
  - out_valid in the cycle after accept.
  - dbz takes priority over ovf.
- IDLE → BUSY otherwise:
  - Partial remainder R (W+1 bits) loaded with {0, dividend[2W-1:W]}.
  - Shift register loaded with dividend[W-1:0]; counter=W.
- BUSY, each cycle:
  - T = {R[W-1:0], next dividend bit (MSB first)}.
  - If T >= {0,divisor}: R=T-divisor, shift 1 into quotient LSB; else R=T, shift 0.
  - Counter decrements. When the counter reaches 1 at the clock edge, move to DONE after that iteration.
  - Exactly W BUSY cycles.
- Latency, normal path: accept at cycle 0 → out_valid=1 at cycle W+1 (17 for W=16).
- DONE:
  - out_valid=1; quotient/remainder/dbz/ovf stable until out_ready sampled high.
  - On out_valid && out_ready → IDLE. out_valid drops next cycle; in_ready high that same next cycle.
  - No accept in the DONE cycle; minimum initiation interval is W+2 cycles.
- Outputs hold their last values in IDLE and BUSY; only out_valid qualifies them.
- Arithmetic invariant (non-error): dividend == quotient*divisor + remainder; remainder < divisor.
- in_valid deasserting while in BUSY/DONE has no effect. out_ready high while out_valid=0 is ignored.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Localparam ALL_ONES(W).
  - Flag encoding constants reused by the multiplier error harness.
- One natural sub-module: div_step (combinational). Takes R, next bit, divisor; returns new R and quotient bit. Keeps the datapath separable for a future radix-4 variant.
- FSM, counter and handshake stay in the top.

Test Plan:
- dividend=0x000F4240, divisor=0x03E8, out_ready=1 → out_valid at cycle 17 after accept; quotient=0x03E8, remainder=0x0000, dbz=0, ovf=0.
- dividend=0x00123456, divisor=0x0100 → quotient=0x1234, remainder=0x0056. Also dividend=0x0000FFFF, divisor=0x0007 → quotient=0x2492, remainder=0x0001.
- divisor=0x0000, dividend=0xDEADBEEF → out_valid 1 cycle after accept; dbz=1, ovf=0, quotient=0xFFFF, remainder=0xBEEF. Same with dividend=0x12345678, divisor=0x1234 → ovf=1, dbz=0, quotient=0xFFFF, remainder=0x5678.
- Backpressure: out_ready low for 5 cycles after out_valid → all outputs stable, in_ready=0; in_valid held high with new operands is not accepted until the cycle after the out_ready handshake.
- Assert rst at BUSY cycle 8 → asynchronously out_valid=0, in_ready=1, quotient=remainder=0. The next operation (0x00000064/0x000A) yields quotient=0x000A, remainder=0x0000 with full 17-cycle latency.
- Random regression: 10k operands, including divisor=1, divisor=0xFFFF, dividend=0xFFFEFFFF (max non-overflow) → matches golden model; non-error results satisfy the invariant.
